// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and the baud divisor helper used by uart_rx and uart_tx.
// Contents: rx_state_t receiver FSM states; uart_divisor() clk cycles per bit.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   function automatic int uart_divisor(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO holding received bytes until the consumer pops them.
// Ports: clk, n_reset (async, active-low); push/din write a byte; pop removes the head;
//        dout is the head byte; full/empty report occupancy.
// A push while full is ignored unless a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];
   logic        do_push, do_pop;

   // Pointers carry one extra MSB so equal low bits with differing MSBs means full.
   assign empty = wr_q == rd_q;
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + {{AW{1'b0}}, do_push};
      rd_d = rd_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '{default: '0};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, buffered valid/ready output and sticky errors.
// Ports: clk, n_reset (async, active-low); rx_pin serial input (idle high);
//        rx_data/rx_valid/rx_ready head-of-buffer handshake; frame_err, overrun sticky flags
//        cleared by err_clr; busy while the receiver is not idle.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO, otherwise a single holding register.
module uart_rx #(
   parameter int UART_CLK_HZ = 27000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       err_clr,
   output logic       busy
);

   import uart_pkg::*;

   localparam int DIVISOR = uart_divisor(UART_CLK_HZ, BAUD_RATE);
   localparam int HALF    = DIVISOR / 2;
   localparam int CW      = $clog2(DIVISOR);
   localparam logic [CW-1:0] DIV_END  = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   rx_state_t   state_q, state_d;
   logic [1:0]  sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        busy_q, busy_d;
   logic        rx_s, push, ferr_set, pop, full;

   assign rx_s = sync_q[1];
   assign pop  = rx_valid && rx_ready;

   always_comb begin
      sync_d   = {sync_q[0], rx_pin};
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: if (cnt_q == HALF_END) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt_q == DIV_END) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = STOP;
         end
         STOP: if (cnt_q == DIV_END) begin
            cnt_d    = '0;
            push     = rx_s;
            ferr_set = !rx_s;
            state_d  = rx_s ? IDLE : BREAK;
         end
         BREAK: begin
            // A low line here is a break or a broken frame, never a new start bit.
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d      = state_d != IDLE;
      // Clearing wins over a same-cycle set; that set event is lost.
      frame_err_d = err_clr ? 1'b0 : frame_err_q | ferr_set;
      overrun_d   = err_clr ? 1'b0 : overrun_q | (push && full && !pop);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

`ifdef UART_RX_FIFO_EN
   logic empty;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (push),
      .pop     (pop),
      .din     (shift_q),
      .dout    (rx_data),
      .full    (full),
      .empty   (empty)
   );

   assign rx_valid = !empty;
`else
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;

   // A push into a full register only lands if the current byte is popped that cycle.
   always_comb begin
      data_d  = (push && (!valid_q || pop)) ? shift_q : data_q;
      valid_d = push || (valid_q && !pop);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign full     = valid_q;
   assign rx_data  = data_q;
   assign rx_valid = valid_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frame checks of uart_rx against a byte-queue model.
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       rx_pin = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   logic       fe_exp = 1'b0;
   logic       ov_exp = 1'b0;

   uart_rx #(
      .UART_CLK_HZ (1600),
      .BAUD_RATE   (100),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .rx_pin    (rx_pin),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ov_exp = 1'b1;
   endtask

   // One 8N1 frame, 16 cycles per bit; optionally pops exactly on the cycle the byte completes.
   task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_on_push);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         if (pop_on_push) rx_ready = (k == 154);
         rx_pin = fr[k/16];
      end
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pop_chk(input string tag);
      @(negedge clk);
      chk({tag, "_valid"}, {7'd0, rx_valid}, 8'd1);
      chk({tag, "_data"}, rx_data, exp_q[0]);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(exp_q.pop_front());
      chk({tag, "_after"}, {7'd0, rx_valid}, {7'd0, exp_q.size() != 0});
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() != 0) pop_chk(tag);
      chk({tag, "_empty"}, {7'd0, rx_valid}, 8'd0);
   endtask

   task automatic flags_chk(input string tag);
      chk({tag, "_fe"}, {7'd0, frame_err}, {7'd0, fe_exp});
      chk({tag, "_ov"}, {7'd0, overrun}, {7'd0, ov_exp});
   endtask

   task automatic clear_flags();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      fe_exp = 1'b0;
      ov_exp = 1'b0;
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] b;
      repeat (3) @(negedge clk);
      chk("rst_valid", {7'd0, rx_valid}, 8'd0);
      chk("rst_data", rx_data, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      flags_chk("rst");
      n_reset = 1'b1;
      repeat (4) @(negedge clk);

      // Clean 0x55 with exact busy-rise and rx_valid-rise timing.
      fr = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 176; k++) begin
         @(negedge clk);
         if (k == 2) chk("t1_busy_pre", {7'd0, busy}, 8'd0);
         if (k == 3) chk("t1_busy", {7'd0, busy}, 8'd1);
         if (k == 154) chk("t1_valid_pre", {7'd0, rx_valid}, 8'd0);
         if (k == 155) begin
            chk("t1_valid", {7'd0, rx_valid}, 8'd1);
            chk("t1_data", rx_data, 8'h55);
         end
         rx_pin = (k < 160) ? fr[k/16] : 1'b1;
      end
      model_push(8'h55);
      drain("t1");
      flags_chk("t1");

      // Start-bit glitch of 4 cycles.
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 5) chk("t2_busy", {7'd0, busy}, 8'd1);
         rx_pin = (k < 4) ? 1'b0 : 1'b1;
      end
      chk("t2_busy_end", {7'd0, busy}, 8'd0);
      chk("t2_valid", {7'd0, rx_valid}, 8'd0);
      flags_chk("t2");

      // Bad stop bit followed by a long break.
      send_byte(8'hA3, 1'b0, 0);
      fe_exp = 1'b1;
      flags_chk("t3_stop");
      repeat (640) @(negedge clk);
      chk("t3_brk_busy", {7'd0, busy}, 8'd1);
      chk("t3_brk_valid", {7'd0, rx_valid}, 8'd0);
      rx_pin = 1'b1;
      repeat (6) @(negedge clk);
      chk("t3_idle", {7'd0, busy}, 8'd0);
      send_byte(8'h3C, 1'b1, 0);
      model_push(8'h3C);
      drain("t3");
      flags_chk("t3_fe");
      clear_flags();
      flags_chk("t3_clr");

      // Overflow the buffer with 0x01..0x05.
      for (int i = 1; i <= 5; i++) begin
         send_byte(8'(i), 1'b1, 0);
         model_push(8'(i));
      end
      flags_chk("t4");
      drain("t4");
      clear_flags();
      flags_chk("t4_clr");

      // Full buffer, pop coincides with the completing push.
      for (int i = 1; i <= DEPTH; i++) begin
         send_byte(8'(i), 1'b1, 0);
         model_push(8'(i));
      end
      send_byte(8'h05, 1'b1, 1);
      void'(exp_q.pop_front());
      model_push(8'h05);
      flags_chk("t5");
      drain("t5");

      // Random bytes with random pops.
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b1, 0);
         model_push(b);
         if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) pop_chk("rnd");
      end
      flags_chk("rnd");
      drain("rnd");
      clear_flags();

      // Reset in the middle of bit 3 with a byte buffered and frame_err set.
      send_byte(8'h00, 1'b0, 0);
      rx_pin = 1'b1;
      repeat (8) @(negedge clk);
      send_byte(8'h11, 1'b1, 0);
      fr = {1'b1, 8'h99, 1'b0};
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         rx_pin = fr[k/16];
      end
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      chk("t6_valid", {7'd0, rx_valid}, 8'd0);
      chk("t6_data", rx_data, 8'd0);
      chk("t6_busy", {7'd0, busy}, 8'd0);
      exp_q.delete();
      fe_exp = 1'b0;
      ov_exp = 1'b0;
      flags_chk("t6_rst");
      repeat (3) @(negedge clk);
      rx_pin = 1'b1;
      n_reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("t6_busy_rel", {7'd0, busy}, 8'd0);
      send_byte(8'h7E, 1'b1, 0);
      model_push(8'h7E);
      drain("t6");
      flags_chk("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the SoC: the receive-side counterpart of `uart_tx`, using the same clock and baud parameters and the same 8N1 framing. It synchronises the external RX pin and recovers bytes by mid-bit sampling. Received bytes are buffered and presented on a valid/ready interface so the CPU bus decode can pop them. Framing errors and overruns are reported as sticky status flags.

## Interface
- UART_CLK_HZ, 27000000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate.
- FIFO_DEPTH, 4, buffer entries when `UART_RX_FIFO_EN` is defined.
  - Must be a power of two, at least 2.
  - Ignored otherwise.

- clk  in  1  system clock.
- n_reset  in  1  asynchronous, active-low reset.
- rx_pin  in  1  serial input, idle high, asynchronous to clk.
- rx_data  out  8  head-of-buffer byte; meaningful only while rx_valid=1.
- rx_valid  out  1  buffer non-empty.
- rx_ready  in  1  consumer pop request.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a completed byte was dropped because the buffer was full.
- err_clr  in  1  clears frame_err and overrun.
- busy  out  1  receiver state is not IDLE.

## Operation
- DIVISOR = UART_CLK_HZ / BAUD_RATE, integer truncation (234 at defaults). HALF = DIVISOR / 2.
- rx_pin passes through a 2-flop synchroniser (reset value 1). rx_s is the synchroniser output. The FSM sees only rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, go to START and clear the bit-period counter.
  - START: at count HALF-1, sample rx_s.
    - rx_s=1: glitch, return to IDLE and discard.
    - rx_s=0: go to DATA.
  - DATA: sample every DIVISOR cycles, 8 bits, LSB first, shifting into a shift register. After bit 7, go to STOP.
  - STOP: sample after DIVISOR cycles.
    - rx_s=1: push the byte and return to IDLE.
    - rx_s=0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. No new start bit is detected while the line stays low.
- Push and pop rules:
  - Pop occurs when rx_valid && rx_ready.
  - Push when full: the byte is dropped, overrun is set, and buffer contents are unchanged.
  - Push and pop in the same cycle when full: both are performed, no overrun.
  - Push and pop in the same cycle when empty: cannot occur (rx_valid=0).
- Error flags:
  - err_clr has priority over a same-cycle set event: the flag ends up 0 and that event is lost.
  - frame_err and overrun are set independently of each other.
- Reset (asynchronous, including mid-byte):
  - FSM returns to IDLE; buffer and pointers are emptied.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchroniser=1.
  - After reset, the first falling edge is treated as a new start bit.

## Timing
- rx_pin low at clk edge e gives rx_s=0 from edge e+2. Call t0 the cycle IDLE sees rx_s=0.
- Sample points:
  - Start-bit check at t0+HALF.
  - Data bit i (0..7) at t0+HALF+(i+1)·DIVISOR.
  - Stop bit at t0+HALF+9·DIVISOR.
- rx_valid rises the cycle after the stop sample. rx_data is stable from that same cycle.
- Pop: rx_valid and rx_data update one cycle after the pop edge.
- frame_err rises the cycle after a bad stop sample.
- busy goes high the cycle after t0 and low the cycle after return to IDLE.
- All outputs are registered.

## Configuration
- `UART_RX_FIFO_EN` defined: the buffer is a FIFO_DEPTH-entry circular FIFO.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB compare.
  - Full means FIFO_DEPTH bytes are held.
- Undefined: the buffer is a single holding register (depth 1), with identical handshake, overrun and reset semantics.

## Structure
- Package `uart_pkg`:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK).
  - uart_divisor(clk_hz, baud) function, shareable with uart_tx.
- Sub-module `uart_rx_fifo`:
  - Parameterised depth with push/pop/full/empty.
  - Instantiated only under `UART_RX_FIFO_EN`.
- Synchroniser, FSM and error flags stay in uart_rx.

## Test plan
All scenarios use UART_CLK_HZ=1600 and BAUD_RATE=100 (DIVISOR=16, HALF=8).
- Send 0x55 as a clean 8N1 frame -> stop sampled at t0+152; rx_valid=1 at t0+153 with rx_data=0x55; pulse rx_ready -> rx_valid=0 next cycle; no flags.
- rx_pin low for 4 cycles, then high -> no byte, busy returns to 0, no flags.
- Send 0xA3 with stop bit low, then hold the line low for 40 bit periods -> frame_err=1, rx_valid=0, no further bytes; line high then send 0x3C -> 0x3C received; err_clr -> frame_err=0.
- FIFO enabled, depth 4: send 0x01..0x05 without popping -> overrun=1; pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0. Macro off: only 0x01 is retained and overrun=1.
- Buffer full, rx_ready held high on the cycle the 5th byte completes -> no overrun; bytes 0x02..0x05 remain in order.
- n_reset asserted at bit 3 of a frame -> all outputs 0, busy=0 during reset; release reset, then send 0x7E -> received correctly.
